// File: rtl/key_evt_pkg.sv
// Shared constants for the key event queue: event type codes, FSM state
// encoding and the key-code width.
package key_evt_pkg;

  localparam int KCODE_W = 3;
  localparam int ETYPE_W = 2;
  localparam int EVT_W   = ETYPE_W + KCODE_W;

  localparam logic [ETYPE_W-1:0] EVT_SHORT    = 2'b00;
  localparam logic [ETYPE_W-1:0] EVT_LONG     = 2'b01;
  localparam logic [ETYPE_W-1:0] EVT_REPEAT   = 2'b10;
  localparam logic [ETYPE_W-1:0] EVT_LONG_REL = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    WAIT_REL = 3'd4
  } key_state_e;

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead event FIFO with a sticky overflow flag for pushes dropped while full.
// Handshake: an entry leaves the FIFO on a clock edge where valid_o && pop_i.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [EVT_W-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clr_ovf_i,
  output logic             valid_o,
  output logic [EVT_W-1:0] head_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, do_pop, wr_en;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign do_pop = pop_i && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign wr_en  = push_i && (!full || do_pop);

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    unique case ({wr_en, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_i && !wr_en)  overflow_d = 1'b1;
    else if (clr_ovf_i)    overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o    = !empty;
  assign head_o     = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced press/release ticks into SHORT/LONG/REPEAT/LONG_RELEASE
// events timed on a 1 ms base, and queues them for the menu logic.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int TICK_DIV  = 22118,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               press_tick,
  input  logic               release_tick,
  input  logic [KCODE_W-1:0] kcode,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [KCODE_W-1:0] evt_code,
  output logic [ETYPE_W-1:0] evt_type,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic               key_held
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(LONG_MS + 1);
  localparam int RW = $clog2(REPEAT_MS + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_MS - 1);

  key_state_e         state_q, state_d;
  logic [PW-1:0]      pre_cnt_q, pre_cnt_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]      rpt_cnt_q, rpt_cnt_d;
  logic [KCODE_W-1:0] code_q, code_d;
  logic               ms_tick, push;
  logic [ETYPE_W-1:0] push_type;
  logic [EVT_W-1:0]   head;

  assign ms_tick = (pre_cnt_q == PRE_LAST);

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = ms_tick ? '0 : pre_cnt_q + 1'b1;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    code_d     = code_q;
    push       = 1'b0;
    push_type  = EVT_SHORT;
    unique case (state_q)
      IDLE: begin
        if (press_tick) state_d = CAPTURE;
      end
      CAPTURE: begin
        // Restarting the prescaler here makes the first ms tick land exactly TICK_DIV edges in.
        code_d     = kcode;
        hold_cnt_d = '0;
        rpt_cnt_d  = '0;
        pre_cnt_d  = '0;
        state_d    = (kcode == '0) ? WAIT_REL : HELD;
      end
      HELD: begin
        if (ms_tick) hold_cnt_d = hold_cnt_q + 1'b1;
        if (release_tick) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (ms_tick && hold_cnt_q == HOLD_LAST) begin
          push      = 1'b1;
          push_type = EVT_LONG;
          state_d   = REPEAT;
        end
      end
      REPEAT: begin
        if (ms_tick) rpt_cnt_d = rpt_cnt_q + 1'b1;
        if (release_tick) begin
          push      = 1'b1;
          push_type = EVT_LONG_REL;
          state_d   = IDLE;
        end else if (ms_tick && rpt_cnt_q == RPT_LAST) begin
          push      = 1'b1;
          push_type = EVT_REPEAT;
          rpt_cnt_d = '0;
        end
      end
      WAIT_REL: begin
        if (release_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      code_q     <= code_d;
    end
  end

  key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i ({push_type, code_q}),
    .pop_i       (evt_ready),
    .clr_ovf_i   (clr_overflow),
    .valid_o     (evt_valid),
    .head_o      (head),
    .overflow_o  (overflow)
  );

  assign evt_code = head[KCODE_W-1:0];
  assign evt_type = head[EVT_W-1:KCODE_W];
  assign key_held = (state_q == HELD) || (state_q == REPEAT);

endmodule
